// File: rtl/pr_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single-access-per-cycle peripheral bridge.
// Optional locked re-grant with starvation limit is built only when PR_ARB_LOCK_EN is defined.
module pr_bus_arbiter #(
    parameter int LOCK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic [31:0] m0_rd,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic [31:0] m1_rd,
    output logic        PrWe,
    output logic [31:0] PrAddr,
    output logic [31:0] PrWD,
    input  logic [31:0] PrRD,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_q;
    logic   last_d;
    logic   any_req_s;
    logic   rr_pick1_s;
    logic   pick1_s;

    assign any_req_s  = m0_req | m1_req;
    // last_q=1 means master 1 owned last, so master 0 wins a tie
    assign rr_pick1_s = m1_req & (~m0_req | ~last_q);

`ifdef PR_ARB_LOCK_EN
    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             own1_s;
    logic             own_lock_s;
    logic             other_req_s;

    // Owner pick with lock override; the counter forces a hand-over once the limit is reached
    always_comb begin
        pick1_s     = rr_pick1_s;
        cnt_d       = '0;
        own1_s      = (state_q == GNT1);
        own_lock_s  = own1_s ? (m1_lock & m1_req) : (m0_lock & m0_req);
        other_req_s = own1_s ? m0_req : m1_req;
        if ((state_q != IDLE) && own_lock_s) begin
            if (other_req_s && (cnt_q == CNT_LAST)) begin
                pick1_s = ~own1_s;
                cnt_d   = '0;
            end else begin
                pick1_s = own1_s;
                cnt_d   = other_req_s ? (cnt_q + CNT_W'(1)) : '0;
            end
        end else begin
            pick1_s = rr_pick1_s;
            cnt_d   = '0;
        end
    end

    // Consecutive locked-grant counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_lock_s;

    assign unused_lock_s = m0_lock ^ m1_lock;
    assign pick1_s       = rr_pick1_s;
`endif

    // Next owner decision; the winner becomes last owner
    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        if (any_req_s) begin
            state_d = pick1_s ? GNT1 : GNT0;
            last_d  = pick1_s;
        end else begin
            state_d = IDLE;
            last_d  = last_q;
        end
    end

    // State and last-owner registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Bridge and master outputs steered by the registered owner only
    always_comb begin
        PrWe   = 1'b0;
        PrAddr = 32'd0;
        PrWD   = 32'd0;
        m0_ack = 1'b0;
        m0_rd  = 32'd0;
        m1_ack = 1'b0;
        m1_rd  = 32'd0;
        case (state_q)
            GNT0: begin
                PrWe   = m0_we;
                PrAddr = m0_addr;
                PrWD   = m0_wd;
                m0_ack = 1'b1;
                m0_rd  = PrRD;
            end
            GNT1: begin
                PrWe   = m1_we;
                PrAddr = m1_addr;
                PrWD   = m1_wd;
                m1_ack = 1'b1;
                m1_rd  = PrRD;
            end
            default: begin
                PrWe = 1'b0;
            end
        endcase
    end

    assign grant = {(state_q == GNT1), (state_q == GNT0)};

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Randomized and directed bench for pr_bus_arbiter against a cycle-level owner model.
module tb_pr_bus_arbiter;

    localparam int LOCK_MAX = 4;
`ifdef PR_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_lock, m0_ack;
    logic [31:0] m0_addr, m0_wd, m0_rd;
    logic        m1_req, m1_we, m1_lock, m1_ack;
    logic [31:0] m1_addr, m1_wd, m1_rd;
    logic        PrWe;
    logic [31:0] PrAddr, PrWD, PrRD;
    logic [1:0]  grant;

    int n_cmp;
    int n_err;
    int m_own;
    int m_last;
    int m_cnt;
    bit glitch1;
    int m1_grants;

    pr_bus_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rd(m1_rd),
        .PrWe(PrWe), .PrAddr(PrAddr), .PrWD(PrWD), .PrRD(PrRD), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, check outputs at the falling edge, then advance the owner model.
    task automatic step(input logic rst,
                        input logic r0, input logic w0, input logic [31:0] a0,
                        input logic [31:0] d0, input logic l0,
                        input logic r1, input logic w1, input logic [31:0] a1,
                        input logic [31:0] d1, input logic l1,
                        input logic [31:0] prd, input int exp_g);
        logic [1:0]  eg;
        logic        ewe;
        logic [31:0] ead, ewd;
        bit          rq[2];
        bit          lk[2];
        int          nxt;
        int          oth;
        reset = rst;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wd = d0; m0_lock = l0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wd = d1; m1_lock = l1;
        PrRD = prd;
        #4;
        eg  = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
        ewe = (m_own == 0) ? m0_we : (m_own == 1) ? m1_we : 1'b0;
        ead = (m_own == 0) ? m0_addr : (m_own == 1) ? m1_addr : 32'd0;
        ewd = (m_own == 0) ? m0_wd : (m_own == 1) ? m1_wd : 32'd0;
        check("grant", {30'd0, grant}, {30'd0, eg});
        check("PrWe", {31'd0, PrWe}, {31'd0, ewe});
        check("PrAddr", PrAddr, ead);
        check("PrWD", PrWD, ewd);
        check("m0_ack", {31'd0, m0_ack}, (m_own == 0) ? 32'd1 : 32'd0);
        check("m1_ack", {31'd0, m1_ack}, (m_own == 1) ? 32'd1 : 32'd0);
        check("m0_rd", m0_rd, (m_own == 0) ? PrRD : 32'd0);
        check("m1_rd", m1_rd, (m_own == 1) ? PrRD : 32'd0);
        if (exp_g >= 0) check("grant_seq", {30'd0, grant}, exp_g);
        if (m1_ack === 1'b1) m1_grants++;
        if (glitch1) begin
            m1_req  = 1'b0;
            glitch1 = 1'b0;
        end
        rq[0] = m0_req; rq[1] = m1_req;
        lk[0] = m0_lock; lk[1] = m1_lock;
        if (reset) begin
            m_own = -1; m_last = 1; m_cnt = 0;
        end else begin
            if (LOCK_EN && m_own >= 0 && rq[m_own] && lk[m_own]) begin
                oth = 1 - m_own;
                if (rq[oth] && m_cnt == LOCK_MAX - 1) begin
                    nxt = oth; m_cnt = 0;
                end else begin
                    nxt = m_own; m_cnt = rq[oth] ? m_cnt + 1 : 0;
                end
            end else begin
                m_cnt = 0;
                if (rq[0] && rq[1]) nxt = 1 - m_last;
                else if (rq[0])     nxt = 0;
                else if (rq[1])     nxt = 1;
                else                nxt = -1;
            end
            if (nxt >= 0) m_last = nxt;
            m_own = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int exp_g);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, exp_g);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, -1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; glitch1 = 1'b0; m1_grants = 0;
        m_own = -1; m_last = 1; m_cnt = 0;
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wd = 32'd0; m0_lock = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wd = 32'd0; m1_lock = 1'b0;
        PrRD = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        idle(0);

        // m0 single write, request dropped once the ack is seen
        step(1'b0, 1'b1, 1'b1, 32'h7F34, 32'hAA, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b0, 1'b1, 32'h7F34, 32'hAA, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1);
        idle(0);

        // both masters read right after reset: 01,10,01,10
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 1'b0, 32'h200, 32'd0, 1'b0, 32'hA1, 0);
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 1'b0, 32'h200, 32'd0, 1'b0, 32'hA2, 1);
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 1'b0, 32'h200, 32'd0, 1'b0, 32'hA3, 2);
        step(1'b0, 1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1, 1'b0, 32'h200, 32'd0, 1'b0, 32'hA4, 1);
        step(1'b0, 1'b0, 1'b0, 32'h100, 32'd0, 1'b0, 1'b0, 1'b0, 32'h200, 32'd0, 1'b0, 32'hA5, 2);
        idle(0);

        // m0 read returns bridge data
        step(1'b0, 1'b1, 1'b0, 32'h7F2C, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h12345678, 0);
        step(1'b0, 1'b0, 1'b0, 32'h7F2C, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'h12345678, 1);
        check("m0_rd_7F2C", m0_rd, 32'd0);
        idle(0);

        // reset while m1 write is granted, then reissue
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h55, 1'b0, 32'd0, 0);
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h55, 1'b0, 32'd0, 2);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h55, 1'b0, 32'd0, 0);
        step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h55, 1'b0, 32'd0, 2);
        idle(0);

        // m1 pulses req inside an m0 grant cycle and withdraws it before the edge
        m1_grants = 0;
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 0);
        glitch1 = 1'b1;
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 1'b0, 1'b0, 32'h20, 32'd0, 1'b0, 32'd0, 1);
        idle(0);
        check("m1_never_granted", m1_grants, 32'd0);

`ifdef PR_ARB_LOCK_EN
        // locked m0 gets four grants, then m1 once, then m0 again
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h1, 32'd0, 1'b1, 1'b1, 1'b0, 32'h2, 32'd0, 1'b0, 32'd0, 0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 32'h1, 32'd0, 1'b1, 1'b1, 1'b0, 32'h2, 32'd0, 1'b0, 32'd0, 1);
        step(1'b0, 1'b1, 1'b0, 32'h1, 32'd0, 1'b1, 1'b1, 1'b0, 32'h2, 32'd0, 1'b0, 32'd0, 2);
        step(1'b0, 1'b0, 1'b0, 32'h1, 32'd0, 1'b0, 1'b0, 1'b0, 32'h2, 32'd0, 1'b0, 32'd0, 1);
        idle(0);
`endif

        // randomized traffic against the owner model
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom, $urandom,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 6), $urandom_range(0, 1), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0),
                 $urandom, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pr_bus_arbiter.md
PR_BUS_ARBITER -- requirements
Module: pr_bus_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 4: maximum consecutive locked grants to one master while the other master is requesting.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port m0_req  in  1  master 0 (CPU) access request; held high until m0_ack.
REQ-005 SHALL have port m0_we  in  1  master 0 write (1) / read (0).
REQ-006 SHALL have port m0_addr  in  32  master 0 byte address.
REQ-007 SHALL have port m0_wd  in  32  master 0 write data.
REQ-008 SHALL have port m0_lock  in  1  master 0 request to keep the grant for its next access.
REQ-009 SHALL have port m0_ack  out  1  master 0 access completes this cycle.
REQ-010 SHALL have port m0_rd  out  32  master 0 read data, valid while m0_ack.
REQ-011 SHALL have ports m1_req, m1_we, m1_addr, m1_wd, m1_lock, m1_ack, m1_rd, identical to REQ-004..REQ-010, for master 1 (debug/DMA).
REQ-012 SHALL have port PrWe  out  1  write enable to the peripheral bridge.
REQ-013 SHALL have port PrAddr  out  32  address to the bridge.
REQ-014 SHALL have port PrWD  out  32  write data to the bridge.
REQ-015 SHALL have port PrRD  in  32  combinational read data from the bridge.
REQ-016 SHALL have port grant  out  2  one-hot current owner, {g1,g0}; 2'b00 when idle.

Function
REQ-017 SHALL implement FSM states IDLE, GNT0, GNT1; each GNTx cycle performs exactly one bridge access.
REQ-018 IDLE: no requests -> stay IDLE; exactly one request -> that master's GNT next cycle; both -> round-robin pick.
REQ-019 Round robin: when both request and no lock applies, SHALL grant the master not granted last; last_owner resets to 1, so master 0 wins the first tie.
REQ-020 Latency: req rising in IDLE at cycle n -> grant and ack at cycle n+1; accesses from one master may be back-to-back, one per cycle.
REQ-021 In GNTx: PrAddr=mx_addr, PrWD=mx_wd, PrWe=mx_we, mx_ack=1, mx_rd=PrRD (combinational); other master's ack=0 and rd=0.
REQ-022 Outside GNTx: PrWe=0, PrAddr=0, PrWD=0, both acks 0, both rd 0; PrWe SHALL never assert outside a grant cycle.
REQ-023 GNTx next state: re-evaluate per REQ-018/REQ-019 from current requests (x's req sampled after its ack is treated as a new access); go to IDLE if none.
REQ-024 A master dropping req in a cycle it is not granted SHALL withdraw the request; no ack is issued for it.
REQ-025 Grant decisions SHALL be registered; outputs SHALL depend only on state and current master inputs, with no combinational path from PrRD to state.

Reset
REQ-026 Reset SHALL force state IDLE, grant=2'b00, last_owner=1, lock counter=0, and all outputs to 0 on the next edge.
REQ-027 Reset asserted during GNTx SHALL suppress that cycle's PrWe and ack from the next edge; the interrupted access SHALL be reissued by the master.

Configuration
REQ-028 Macro PR_ARB_LOCK_EN defined: master x ending a GNTx cycle with mx_lock=1 and mx_req=1 SHALL be granted again ahead of round robin; a counter SHALL count consecutive locked grants while the other master requests and, at LOCK_MAX, SHALL force the grant to the other master and clear the counter; the counter SHALL clear on any owner change or when the other master is not requesting.
REQ-029 Macro PR_ARB_LOCK_EN undefined: m0_lock and m1_lock SHALL be ignored, no counter SHALL be built, and arbitration SHALL be pure round robin.

Verification
REQ-030 m0 single write 0x7F34 <- 0x000000AA from IDLE -> next cycle grant=01, PrWe=1, PrAddr=0x7F34, m0_ack=1; following cycle IDLE.
REQ-031 m0 and m1 both read on the same cycle after reset, held -> grants alternate 01,10,01,10; acks alternate; m1_rd equals PrRD while granted.
REQ-032 m0 reading 0x7F2C while PrRD=0x12345678 -> m0_rd=0x12345678 during ack; PrWe=0 throughout.
REQ-033 PR_ARB_LOCK_EN, LOCK_MAX=4, m0 req+lock held, m1 req held -> four consecutive grant=01, then one grant=10, then m0 again.
REQ-034 reset asserted during GNT1 of an m1 write -> next cycle grant=00, PrWe=0, m1_ack=0; after release, m1 granted again and write completes once.
REQ-035 m1 asserts req for one cycle while m0 is granted, then drops it -> m1 never granted; m1_ack stays 0.
